// File: rtl/memory_stage.sv
// memory_stage: pipeline stage between execute and writeback.
//
// Purpose:
//   Accepts one execute bundle at a time. ALU ops are registered straight
//   through. Memory ops are checked for alignment. Aligned ops are issued on
//   the data bus and held until the bus responds. Load data is then aligned
//   to its byte lane and sign- or zero-extended. The result is held until
//   writeback consumes it.
//
// Ports:
//   clk, reset (async, active-low)
//   in_*       execute bundle; in_valid/in_ready handshake
//   flush      kill all in-stage work
//   dreq_*     data bus request (valid, addr, size, strobe, data)
//   dresp_*    one-cycle bus response with raw 8-byte-aligned read data
//   out_*      writeback bundle; out_valid/out_ready handshake
module memory_stage #(
  parameter int XLEN = 64,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [REGW-1:0] in_dst,
  input  logic [XLEN-1:0] in_aluout,
  input  logic [XLEN-1:0] in_wdata,
  input  logic            in_regwrite,
  input  logic            in_memread,
  input  logic            in_memwrite,
  input  logic [1:0]      in_msize,
  input  logic            in_unsigned,
  input  logic            flush,
  output logic            dreq_valid,
  output logic [XLEN-1:0] dreq_addr,
  output logic [2:0]      dreq_size,
  output logic [7:0]      dreq_strobe,
  output logic [XLEN-1:0] dreq_data,
  input  logic            dresp_data_ok,
  input  logic [XLEN-1:0] dresp_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [REGW-1:0] out_dst,
  output logic [XLEN-1:0] out_writedata,
  output logic            out_regwrite,
  output logic            out_misalign
);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;

  state_t          state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [REGW-1:0] dst_q, dst_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic            regwrite_q, regwrite_d;
  logic            store_q, store_d;
  logic [1:0]      msize_q, msize_d;
  logic            zext_q, zext_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            out_regwrite_q, out_regwrite_d;
  logic            misalign_q, misalign_d;

  logic            accept;
  logic            in_mem;
  logic            in_misalign;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] load_shifted;
  logic [XLEN-1:0] load_result;

  always_comb begin
    in_ready = 1'b0;
    if (!flush) begin
      in_ready = (state_q == IDLE) || ((state_q == FULL) && out_ready);
    end
  end

  assign accept = in_valid && in_ready;
  assign in_mem = in_memread || in_memwrite;

  always_comb begin
    case (in_msize)
      2'd1:    in_misalign = in_aluout[0];
      2'd2:    in_misalign = |in_aluout[1:0];
      2'd3:    in_misalign = |in_aluout[2:0];
      default: in_misalign = 1'b0;
    endcase
  end

  // Load data arrives 8-byte aligned; bring the addressed byte to bit 0
  // before truncating and extending.
  always_comb begin
    size_mask    = 8'hFF;
    load_shifted = dresp_data >> {addr_q[2:0], 3'b000};
    load_result  = load_shifted;
    case (msize_q)
      2'd0: begin
        size_mask   = 8'h01;
        load_result = zext_q ? {{(XLEN-8){1'b0}}, load_shifted[7:0]}
                             : {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      end
      2'd1: begin
        size_mask   = 8'h03;
        load_result = zext_q ? {{(XLEN-16){1'b0}}, load_shifted[15:0]}
                             : {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      end
      2'd2: begin
        size_mask   = 8'h0F;
        load_result = zext_q ? {{(XLEN-32){1'b0}}, load_shifted[31:0]}
                             : {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
      end
      default: begin
        size_mask   = 8'hFF;
        load_result = load_shifted;
      end
    endcase
  end

  // Request fields come straight from the latched bundle, which cannot change
  // while BUSY, so they stay stable until the response.
  assign dreq_valid  = (state_q == BUSY);
  assign dreq_addr   = dreq_valid ? addr_q : '0;
  assign dreq_size   = dreq_valid ? {1'b0, msize_q} : 3'd0;
  assign dreq_strobe = (dreq_valid && store_q) ? (size_mask << addr_q[2:0]) : 8'h00;
  assign dreq_data   = dreq_valid ? (wdata_q << {addr_q[2:0], 3'b000}) : '0;

  assign out_valid     = (state_q == FULL);
  assign out_pc        = pc_q;
  assign out_dst       = dst_q;
  assign out_writedata = result_q;
  assign out_regwrite  = out_regwrite_q;
  assign out_misalign  = misalign_q;

  always_comb begin
    state_d        = state_q;
    kill_d         = kill_q;
    pc_d           = pc_q;
    dst_d          = dst_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    regwrite_d     = regwrite_q;
    store_d        = store_q;
    msize_d        = msize_q;
    zext_d         = zext_q;
    result_d       = result_q;
    out_regwrite_d = out_regwrite_q;
    misalign_d     = misalign_q;

    case (state_q)
      IDLE: ;
      // A bus access cannot be abandoned; a flush only marks it so the
      // response is swallowed. A flush coinciding with the response also kills.
      BUSY: begin
        if (flush) kill_d = 1'b1;
        if (dresp_data_ok) begin
          kill_d = 1'b0;
          if (kill_q || flush) begin
            state_d = IDLE;
          end else begin
            state_d        = FULL;
            result_d       = store_q ? addr_q : load_result;
            out_regwrite_d = store_q ? 1'b0 : regwrite_q;
          end
        end
      end
      FULL: begin
        if (flush || out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Accepting overrides the FULL->IDLE move, giving back-to-back flow.
    if (accept) begin
      pc_d           = in_pc;
      dst_d          = in_dst;
      addr_d         = in_aluout;
      wdata_d        = in_wdata;
      regwrite_d     = in_regwrite;
      store_d        = in_memwrite;
      msize_d        = in_msize;
      zext_d         = in_unsigned;
      result_d       = in_aluout;
      misalign_d     = 1'b0;
      out_regwrite_d = in_regwrite;
      if (in_mem && in_misalign) begin
        state_d        = FULL;
        misalign_d     = 1'b1;
        out_regwrite_d = 1'b0;
      end else if (in_mem) begin
        state_d        = BUSY;
        out_regwrite_d = 1'b0;
      end else begin
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      kill_q         <= 1'b0;
      pc_q           <= '0;
      dst_q          <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      regwrite_q     <= 1'b0;
      store_q        <= 1'b0;
      msize_q        <= 2'd0;
      zext_q         <= 1'b0;
      result_q       <= '0;
      out_regwrite_q <= 1'b0;
      misalign_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      kill_q         <= kill_d;
      pc_q           <= pc_d;
      dst_q          <= dst_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      regwrite_q     <= regwrite_d;
      store_q        <= store_d;
      msize_q        <= msize_d;
      zext_q         <= zext_d;
      result_q       <= result_d;
      out_regwrite_q <= out_regwrite_d;
      misalign_q     <= misalign_d;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a transaction-level
// model of the stage (one pending bus access, one pending output).
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pc = '0;
  logic [4:0]  in_dst = '0;
  logic [63:0] in_aluout = '0;
  logic [63:0] in_wdata = '0;
  logic        in_regwrite = 1'b0;
  logic        in_memread = 1'b0;
  logic        in_memwrite = 1'b0;
  logic [1:0]  in_msize = '0;
  logic        in_unsigned = 1'b0;
  logic        flush = 1'b0;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_data;
  logic        dresp_data_ok = 1'b0;
  logic [63:0] dresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [4:0]  out_dst;
  logic [63:0] out_writedata;
  logic        out_regwrite;
  logic        out_misalign;

  int checks = 0;
  int failures = 0;

  // Responder controls, written only by the driver.
  bit          rand_mode = 1'b0;
  int          dir_lat = 0;
  logic [63:0] dir_data = '0;
  int          stray_req = 0;

  memory_stage #(.XLEN(64), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_dst(in_dst),
    .in_aluout(in_aluout), .in_wdata(in_wdata), .in_regwrite(in_regwrite),
    .in_memread(in_memread), .in_memwrite(in_memwrite), .in_msize(in_msize),
    .in_unsigned(in_unsigned), .flush(flush),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_dst(out_dst), .out_writedata(out_writedata),
    .out_regwrite(out_regwrite), .out_misalign(out_misalign)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] formatLoad(input logic [63:0] raw, input logic [63:0] addr,
                                             input int msize, input bit uns);
    int nbits;
    logic [63:0] b, mask, v;
    b = raw >> (8 * addr[2:0]);
    nbits = 8 << msize;
    if (nbits == 64) return b;
    mask = (64'd1 << nbits) - 64'd1;
    v = b & mask;
    if (!uns && v[nbits-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [7:0] expStrobe(input logic [63:0] addr, input int msize);
    int s;
    s = ((1 << (1 << msize)) - 1) << addr[2:0];
    return s[7:0];
  endfunction

  // Bus responder: answers each request after a latency, plus stray pulses.
  int wait_cnt = 0;
  int rnd_lat = 0;
  int stray_done = 0;
  always begin
    @(posedge clk);
    #2;
    dresp_data_ok = 1'b0;
    if (!reset) begin
      wait_cnt = 0;
    end else if (stray_req != stray_done) begin
      dresp_data_ok = 1'b1;
      dresp_data = {$urandom, $urandom};
      stray_done++;
    end else if (dreq_valid) begin
      if (wait_cnt >= (rand_mode ? rnd_lat : dir_lat)) begin
        dresp_data_ok = 1'b1;
        dresp_data = rand_mode ? {$urandom, $urandom} : dir_data;
        wait_cnt = 0;
        rnd_lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end else if (rand_mode && $urandom_range(0, 7) == 0) begin
      dresp_data_ok = 1'b1;
      dresp_data = {$urandom, $urandom};
    end
  end

  // Reference model: at most one outstanding bus access and one held output.
  bit          m_bus = 0, m_killed = 0, m_have = 0;
  logic [63:0] r_pc, r_addr, r_wdata;
  logic [4:0]  r_dst;
  bit          r_rw, r_store, r_uns;
  int          r_msize;
  logic [63:0] o_pc, o_wd;
  logic [4:0]  o_dst;
  bit          o_rw, o_mis;

  always @(negedge clk) begin
    bit exp_ready, acc;
    if (!reset) begin
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_dreq_valid", dreq_valid, 0);
      checkOutput("rst_out_pc", out_pc, 0);
      checkOutput("rst_out_writedata", out_writedata, 0);
      checkOutput("rst_out_regwrite", out_regwrite, 0);
      checkOutput("rst_out_misalign", out_misalign, 0);
      checkOutput("rst_dreq_strobe", dreq_strobe, 0);
      m_bus = 0; m_killed = 0; m_have = 0;
    end else begin
      exp_ready = !flush && !m_bus && (!m_have || out_ready);
      checkOutput("in_ready", in_ready, exp_ready);
      checkOutput("dreq_valid", dreq_valid, m_bus);
      if (m_bus) begin
        checkOutput("dreq_addr", dreq_addr, r_addr);
        checkOutput("dreq_size", dreq_size, 64'(r_msize));
        checkOutput("dreq_strobe", dreq_strobe, r_store ? expStrobe(r_addr, r_msize) : 8'h00);
        checkOutput("dreq_data", dreq_data, r_wdata << (8 * r_addr[2:0]));
      end
      checkOutput("out_valid", out_valid, m_have);
      if (m_have) begin
        checkOutput("out_pc", out_pc, o_pc);
        checkOutput("out_dst", out_dst, o_dst);
        checkOutput("out_regwrite", out_regwrite, o_rw);
        checkOutput("out_misalign", out_misalign, o_mis);
        if (!o_mis) checkOutput("out_writedata", out_writedata, o_wd);
      end
      acc = in_valid && exp_ready;
      if (m_have && (flush || out_ready)) m_have = 0;
      if (m_bus) begin
        if (flush) m_killed = 1;
        if (dresp_data_ok) begin
          m_bus = 0;
          if (!m_killed) begin
            m_have = 1; o_pc = r_pc; o_dst = r_dst; o_mis = 0;
            o_wd = r_store ? r_addr : formatLoad(dresp_data, r_addr, r_msize, r_uns);
            o_rw = r_store ? 1'b0 : r_rw;
          end
          m_killed = 0;
        end
      end
      if (acc) begin
        if (!(in_memread || in_memwrite)) begin
          m_have = 1; o_pc = in_pc; o_dst = in_dst; o_wd = in_aluout;
          o_rw = in_regwrite; o_mis = 0;
        end else if ((in_aluout % (64'd1 << in_msize)) != 0) begin
          m_have = 1; o_pc = in_pc; o_dst = in_dst; o_wd = in_aluout;
          o_rw = 0; o_mis = 1;
        end else begin
          m_bus = 1; r_pc = in_pc; r_dst = in_dst; r_addr = in_aluout;
          r_wdata = in_wdata; r_rw = in_regwrite; r_store = in_memwrite;
          r_msize = int'(in_msize); r_uns = in_unsigned;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [63:0] pc, input logic [4:0] dst,
                               input logic [63:0] alu, input logic [63:0] wd,
                               input logic rw, input logic rd, input logic wr,
                               input logic [1:0] sz, input logic uns);
    in_valid = 1'b1; in_pc = pc; in_dst = dst; in_aluout = alu; in_wdata = wd;
    in_regwrite = rw; in_memread = rd; in_memwrite = wr; in_msize = sz;
    in_unsigned = uns;
  endtask

  // Hold the driven bundle until the stage takes it; returns just after that edge.
  task automatic acceptOne();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      tick();
    end
    if (!done) checkOutput("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic waitOut();
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) checkOutput("out_timeout", 0, 1);
  endtask

  initial begin
    int kind;
    logic [63:0] addr;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk); #1 reset = 1'b1;

    // ALU op with one-cycle latency, then three back-to-back ops
    tick();
    applyStimulus(64'h100, 5'd5, 64'h1234, 64'h0, 1, 0, 0, 2'd0, 0);
    acceptOne();
    @(negedge clk);
    checkOutput("alu_valid", out_valid, 1);
    checkOutput("alu_wdata", out_writedata, 64'h1234);
    checkOutput("alu_regwrite", out_regwrite, 1);
    checkOutput("alu_dst", out_dst, 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(64'h200 + 4 * i, 5'(6 + i), 64'h10 + i, 64'h0, 1, 0, 0, 2'd0, 0);
      @(negedge clk);
      checkOutput("b2b_ready", in_ready, 1);
      if (i > 0) begin
        checkOutput("b2b_valid", out_valid, 1);
        checkOutput("b2b_data", out_writedata, 64'h10 + i - 1);
      end
    end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_last", out_writedata, 64'h12);

    // Signed then unsigned byte load at 0x1003 with a 3-cycle response
    dir_lat = 3;
    dir_data = 64'h00000000_80000000;
    for (int u = 0; u < 2; u++) begin
      tick();
      applyStimulus(64'h300, 5'd7, 64'h1003, 64'h0, 1, 1, 0, 2'd0, 1'(u));
      acceptOne();
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checkOutput("lb_dreq_valid", dreq_valid, 1);
        checkOutput("lb_dreq_addr", dreq_addr, 64'h1003);
        checkOutput("lb_dreq_strobe", dreq_strobe, 0);
        checkOutput("lb_dreq_size", dreq_size, 0);
      end
      waitOut();
      checkOutput("lb_result", out_writedata, (u == 0) ? 64'hFFFFFFFF_FFFFFF80 : 64'h80);
      checkOutput("lb_regwrite", out_regwrite, 1);
    end

    // Half store at 0x2006
    dir_lat = 1;
    tick();
    applyStimulus(64'h400, 5'd8, 64'h2006, 64'hBEEF, 1, 0, 1, 2'd1, 0);
    acceptOne();
    @(negedge clk);
    checkOutput("sh_strobe", dreq_strobe, 8'hC0);
    checkOutput("sh_data", dreq_data, 64'hBEEF0000_00000000);
    checkOutput("sh_size", dreq_size, 1);
    waitOut();
    checkOutput("sh_regwrite", out_regwrite, 0);
    checkOutput("sh_wdata", out_writedata, 64'h2006);

    // Misaligned word load at 0x3002
    tick();
    applyStimulus(64'h500, 5'd9, 64'h3002, 64'h0, 1, 1, 0, 2'd2, 0);
    acceptOne();
    @(negedge clk);
    checkOutput("mis_dreq_valid", dreq_valid, 0);
    checkOutput("mis_valid", out_valid, 1);
    checkOutput("mis_flag", out_misalign, 1);
    checkOutput("mis_regwrite", out_regwrite, 0);

    // Flush during an outstanding access
    dir_lat = 3;
    tick();
    applyStimulus(64'h600, 5'd10, 64'h4000, 64'h0, 1, 1, 0, 2'd3, 0);
    acceptOne();
    flush = 1'b1;
    @(negedge clk);
    checkOutput("fl_dreq_valid", dreq_valid, 1);
    tick();
    flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("fl_no_out", out_valid, 0);
      checkOutput("fl_not_ready", in_ready, 0);
    end
    @(negedge clk);
    checkOutput("fl_idle_valid", out_valid, 0);
    checkOutput("fl_idle_dreq", dreq_valid, 0);
    checkOutput("fl_idle_ready", in_ready, 1);

    // Output held under writeback back-pressure
    out_ready = 1'b0;
    tick();
    applyStimulus(64'h700, 5'd11, 64'h5555, 64'h0, 1, 0, 0, 2'd0, 0);
    acceptOne();
    applyStimulus(64'h800, 5'd12, 64'h6666, 64'h0, 1, 0, 0, 2'd0, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_writedata, 64'h5555);
      checkOutput("hold_pc", out_pc, 64'h700);
      checkOutput("hold_ready", in_ready, 0);
    end
    tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();

    // Reset mid-access, then a stray response
    dir_lat = 10;
    applyStimulus(64'h900, 5'd13, 64'h5008, 64'h0, 1, 1, 0, 2'd3, 0);
    acceptOne();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("rb_dreq_valid", dreq_valid, 0);
    checkOutput("rb_out_valid", out_valid, 0);
    checkOutput("rb_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    stray_req++;
    @(negedge clk);
    checkOutput("stray_out_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("stray_out_valid2", out_valid, 0);

    // Randomized traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      flush = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        kind = $urandom_range(0, 2);
        addr = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 1) addr[2:0] = 3'd0;
        applyStimulus({$urandom, $urandom}, 5'($urandom), addr, {$urandom, $urandom},
                      1'($urandom), kind == 1, kind == 2, 2'($urandom), 1'($urandom));
      end else begin
        in_valid = 1'b0;
      end
    end
    tick();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (12) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
